// File: rtl/fnd_view_scheduler.sv
// fnd_view_scheduler
// Chooses which time source and which field pair feed the 4-digit FND
// controller. Four views are stepped through with two button pulses:
//   W_HM (00) watch hour:minute      W_SC (01) watch second:centisecond
//   S_MS (10) stopwatch min:sec      S_SC (11) stopwatch sec:centisecond
// btn_mode swaps the watch/stopwatch domain (always landing on the first
// view of the other domain). btn_view swaps the field pair inside the
// current domain. When both pulse together, btn_mode wins.
//
// Optional build macro AUTO_RETURN_EN: when defined, an idle counter
// returns a stopped stopwatch view to W_HM after AUTO_SEC idle seconds.
// When undefined, the stopwatch views stay until btn_mode.
//
// Ports:
//   clk, reset                   clock; asynchronous active-high reset
//   btn_mode, btn_view           single-cycle debounced button pulses
//   w_hour/w_min/w_sec/w_csec    watch fields
//   s_min/s_sec/s_csec           stopwatch fields
//   s_running                    stopwatch counting
//   digit_h, digit_l             left/right two-digit values (clamped to 99)
//   dot                          active-low decimal point (0 = lit)
//   view                         state encoding, registered with the digits
//
// Handshake: there is none. Button pulses are taken in the cycle they are
// high. All outputs are registered and show a new state or input value one
// clk after it.
module fnd_view_scheduler #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int AUTO_SEC = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_view,
  input  logic [6:0] w_hour,
  input  logic [6:0] w_min,
  input  logic [6:0] w_sec,
  input  logic [6:0] w_csec,
  input  logic [6:0] s_min,
  input  logic [6:0] s_sec,
  input  logic [6:0] s_csec,
  input  logic       s_running,
  output logic [6:0] digit_h,
  output logic [6:0] digit_l,
  output logic       dot,
  output logic [1:0] view
);

  localparam int              MS_CYC    = CLK_HZ / 1000;
  localparam int              MS_W      = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;
  localparam logic [MS_W-1:0] MS_LAST   = MS_W'(MS_CYC - 1);
  localparam logic [8:0]      HALF_LAST = 9'd499;

  typedef enum logic [1:0] {
    W_HM = 2'b00,
    W_SC = 2'b01,
    S_MS = 2'b10,
    S_SC = 2'b11
  } state_e;

  state_e          state_q, state_d;
  logic [MS_W-1:0] ms_cnt_q;
  logic [8:0]      half_cnt_q;
  logic            phase_q;
  logic            tick_1ms;
  logic            auto_hit;
  logic [6:0]      digit_h_q, digit_h_d;
  logic [6:0]      digit_l_q, digit_l_d;
  logic            dot_q, dot_d;
  logic [1:0]      view_q, view_d;

  function automatic logic [6:0] clamp99(input logic [6:0] v);
    return (v > 7'd99) ? 7'd99 : v;
  endfunction

  // Free-running timebase: 1 ms tick, and a phase bit that toggles every
  // 500 ticks. The phase drives the 1 Hz blink of the W_HM dot.
  assign tick_1ms = (ms_cnt_q == MS_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_cnt_q   <= '0;
      half_cnt_q <= '0;
      phase_q    <= 1'b0;
    end else begin
      ms_cnt_q <= tick_1ms ? '0 : ms_cnt_q + MS_W'(1);
      if (tick_1ms) begin
        if (half_cnt_q == HALF_LAST) begin
          half_cnt_q <= '0;
          phase_q    <= ~phase_q;
        end else begin
          half_cnt_q <= half_cnt_q + 9'd1;
        end
      end
    end
  end

`ifdef AUTO_RETURN_EN
  localparam int                IDLE_MAX  = AUTO_SEC * 1000;
  localparam int                IDLE_W    = $clog2(IDLE_MAX + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_MAX);

  logic [IDLE_W-1:0] idle_q, idle_d;

  assign auto_hit = (idle_q == IDLE_LAST);

  // The count is kept only while a stopped stopwatch is shown and no button
  // is pressed. Hitting the limit clears it in the same cycle that W_HM is
  // forced.
  always_comb begin
    idle_d = idle_q;
    if (btn_mode || btn_view || auto_hit || !state_q[1] || s_running) begin
      idle_d = '0;
    end else if (tick_1ms) begin
      idle_d = idle_q + IDLE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) idle_q <= '0;
    else       idle_q <= idle_d;
  end
`else
  // No idle counter. A negative AUTO_SEC has no meaning, so this is
  // constant 0; it keeps the parameter referenced in this build.
  assign auto_hit = (AUTO_SEC < 0);
`endif

  // Next state. btn_mode has priority over btn_view, and a button has
  // priority over auto-return.
  always_comb begin
    state_d = state_q;
    if (btn_mode) begin
      state_d = state_q[1] ? W_HM : S_MS;
    end else if (btn_view) begin
      case (state_q)
        W_HM:    state_d = W_SC;
        W_SC:    state_d = W_HM;
        S_MS:    state_d = S_SC;
        default: state_d = S_MS;
      endcase
    end else if (auto_hit) begin
      state_d = W_HM;
    end
  end

  // The output image is computed from the current state and the current
  // inputs, then registered.
  always_comb begin
    digit_h_d = '0;
    digit_l_d = '0;
    dot_d     = 1'b1;
    view_d    = state_q;
    case (state_q)
      W_HM: begin
        digit_h_d = clamp99(w_hour);
        digit_l_d = clamp99(w_min);
        dot_d     = phase_q;
      end
      W_SC: begin
        digit_h_d = clamp99(w_sec);
        digit_l_d = clamp99(w_csec);
        dot_d     = 1'b0;
      end
      S_MS: begin
        digit_h_d = clamp99(s_min);
        digit_l_d = clamp99(s_sec);
        dot_d     = ~s_running;
      end
      default: begin
        digit_h_d = clamp99(s_sec);
        digit_l_d = clamp99(s_csec);
        dot_d     = ~s_running;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= W_HM;
      digit_h_q <= '0;
      digit_l_q <= '0;
      dot_q     <= 1'b1;
      view_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      digit_h_q <= digit_h_d;
      digit_l_q <= digit_l_d;
      dot_q     <= dot_d;
      view_q    <= view_d;
    end
  end

  assign digit_h = digit_h_q;
  assign digit_l = digit_l_q;
  assign dot     = dot_q;
  assign view    = view_q;

endmodule

// File: tb/tb_fnd_view_scheduler.sv
// Testbench for fnd_view_scheduler. It uses a reduced clock rate
// (CLK_HZ=10_000, so one 1 ms tick every 10 clk) and AUTO_SEC=5.
// A reference model written from view/timing rules predicts every output
// cycle into a scoreboard queue. Directed checks confirm the headline
// values.
module tb_fnd_view_scheduler;

  localparam int CLK_HZ     = 10_000;
  localparam int AUTO_SEC   = 5;
  localparam int MS_CYC     = CLK_HZ / 1000;
  localparam int HALF_CYC   = 500 * MS_CYC;
  localparam int IDLE_TICKS = AUTO_SEC * 1000;
  localparam int SB_W       = 17;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_view = 1'b0;
  logic [6:0] w_hour = 7'd13;
  logic [6:0] w_min = 7'd45;
  logic [6:0] w_sec = 7'd0;
  logic [6:0] w_csec = 7'd0;
  logic [6:0] s_min = 7'd0;
  logic [6:0] s_sec = 7'd0;
  logic [6:0] s_csec = 7'd0;
  logic       s_running = 1'b0;
  logic [6:0] digit_h;
  logic [6:0] digit_l;
  logic       dot;
  logic [1:0] view;

  int n_checks = 0;
  int n_errors = 0;

  logic [SB_W-1:0] exp_q[$];

  fnd_view_scheduler #(
    .CLK_HZ  (CLK_HZ),
    .AUTO_SEC(AUTO_SEC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_mode (btn_mode),
    .btn_view (btn_view),
    .w_hour   (w_hour),
    .w_min    (w_min),
    .w_sec    (w_sec),
    .w_csec   (w_csec),
    .s_min    (s_min),
    .s_sec    (s_sec),
    .s_csec   (s_csec),
    .s_running(s_running),
    .digit_h  (digit_h),
    .digit_l  (digit_l),
    .dot      (dot),
    .view     (view)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int clampf(input int v);
    return (v > 99) ? 99 : v;
  endfunction

  // Reference model. View: 0=watch h:m, 1=watch s:cs, 2=stopwatch m:s,
  // 3=stopwatch s:cs. Time is counted in clk edges since reset release.
  // The blink phase and the ms ticks are derived arithmetically from that count.
  int m_view;
  int m_idle;
  int m_cyc;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_view = 0;
      m_idle = 0;
      m_cyc  = 0;
    end else begin
      int  hv, lv, dv, nxt;
      bit  tick, stopw, hit;
      case (m_view)
        0:       begin hv = w_hour; lv = w_min;  dv = (m_cyc / HALF_CYC) % 2; end
        1:       begin hv = w_sec;  lv = w_csec; dv = 0; end
        2:       begin hv = s_min;  lv = s_sec;  dv = s_running ? 0 : 1; end
        default: begin hv = s_sec;  lv = s_csec; dv = s_running ? 0 : 1; end
      endcase
      exp_q.push_back({7'(clampf(hv)), 7'(clampf(lv)), 1'(dv), 2'(m_view)});
      tick  = ((m_cyc % MS_CYC) == MS_CYC - 1);
      stopw = (m_view >= 2);
`ifdef AUTO_RETURN_EN
      hit = (m_idle == IDLE_TICKS);
`else
      hit = 1'b0;
`endif
      if (btn_mode)      nxt = stopw ? 0 : 2;
      else if (btn_view) nxt = m_view ^ 1;
      else if (hit)      nxt = 0;
      else               nxt = m_view;
      if (btn_mode || btn_view || hit || !stopw || s_running) m_idle = 0;
      else if (tick) m_idle = m_idle + 1;
      m_view = nxt;
      m_cyc  = m_cyc + 1;
    end
  end

  // Scoreboard: compare every cycle away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      check("rst_digit_h", digit_h, 0);
      check("rst_digit_l", digit_l, 0);
      check("rst_dot", dot, 1);
      check("rst_view", view, 0);
    end else if (exp_q.size() == 0) begin
      check("sb_underflow", 1, 0);
    end else begin
      logic [SB_W-1:0] e;
      e = exp_q.pop_front();
      check("digit_h", digit_h, e[16:10]);
      check("digit_l", digit_l, e[9:3]);
      check("dot", dot, e[2]);
      check("view", view, e[1:0]);
    end
  end

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rand_data();
    w_hour = 7'($urandom_range(0, 127));
    w_min  = 7'($urandom_range(0, 127));
    w_sec  = 7'($urandom_range(0, 127));
    w_csec = 7'($urandom_range(0, 127));
    s_min  = 7'($urandom_range(0, 127));
    s_sec  = 7'($urandom_range(0, 127));
    s_csec = 7'($urandom_range(0, 127));
  endtask

  task automatic pulse_mode();
    btn_mode = 1'b1;
    step(1);
    btn_mode = 1'b0;
  endtask

  task automatic pulse_view();
    btn_view = 1'b1;
    step(1);
    btn_view = 1'b0;
  endtask

  // Reset edges land 2 time units after a negedge so the scoreboard
  // never samples them in the same step.
  task automatic do_reset(input int n);
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (n) @(negedge clk);
    #2 reset = 1'b0;
  endtask

  initial begin
    bit returned;
    int ret_k;

    // Reset with 13:45 on the watch.
    repeat (3) @(negedge clk);
    check("reset_dot", dot, 1);
    #2 reset = 1'b0;

    // Hold W_HM through two blink half-periods.
    for (int n = 1; n <= 2 * HALF_CYC + 1; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check("first_h", digit_h, 13);
        check("first_l", digit_l, 45);
        check("first_view", view, 0);
        check("first_dot", dot, 0);
      end
      if (n == HALF_CYC)         check("blink_lit_end", dot, 0);
      if (n == HALF_CYC + 1)     check("blink_off_start", dot, 1);
      if (n == 2 * HALF_CYC)     check("blink_off_end", dot, 1);
      if (n == 2 * HALF_CYC + 1) check("blink_lit_again", dot, 0);
      rand_data();
    end

    // Stopwatch views.
    s_min = 7'd2; s_sec = 7'd7; s_csec = 7'd88; s_running = 1'b0;
    pulse_mode();
    step(1);
    check("sms_view", view, 2);
    check("sms_h", digit_h, 2);
    check("sms_l", digit_l, 7);
    check("sms_dot_stopped", dot, 1);
    pulse_view();
    step(1);
    check("ssc_view", view, 3);
    check("ssc_h", digit_h, 7);
    check("ssc_l", digit_l, 88);
    s_running = 1'b1;
    step(1);
    check("running_dot", dot, 0);
    s_running = 1'b0;

    // Both buttons together in W_SC: btn_mode wins.
    pulse_mode();
    pulse_view();
    step(1);
    check("wsc_view", view, 1);
    btn_mode = 1'b1;
    btn_view = 1'b1;
    step(1);
    btn_mode = 1'b0;
    btn_view = 1'b0;
    step(1);
    check("both_btn_view", view, 2);

    // Clamp in W_SC.
    pulse_mode();
    pulse_view();
    w_csec = 7'd120;
    step(1);
    check("clamp_l", digit_l, 99);
    check("wsc_dot", dot, 0);

    // Random traffic, with one reset in the middle.
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      rand_data();
      btn_mode = ($urandom_range(0, 15) == 0);
      btn_view = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0) s_running = ~s_running;
      if (i == 500) begin
        btn_mode = 1'b0;
        btn_view = 1'b0;
        do_reset(2);
      end
    end
    btn_mode = 1'b0;
    btn_view = 1'b0;
    s_running = 1'b0;

    // Auto-return: idle in S_MS, btn_view at 30,000 restarts the count.
    do_reset(2);
    pulse_mode();
    for (int k = 0; k < 30_000; k++) begin
      step(1);
      rand_data();
    end
    check("auto_hold_30k", view, 2);
    pulse_view();
    returned = 1'b0;
    ret_k = 0;
    for (int k = 1; k <= 52_000 && !returned; k++) begin
      step(1);
      rand_data();
      if (view == 2'b00) begin
        returned = 1'b1;
        ret_k = k;
      end
    end
`ifdef AUTO_RETURN_EN
    check("auto_returned", returned, 1);
    check("auto_return_window", (ret_k >= 49_990 && ret_k <= 50_020), 1);
`else
    check("no_auto_return", returned, 0);
    check("no_auto_view", view, 3);
`endif

    step(2);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fnd_view_scheduler.md
Name: fnd_view_scheduler

Overview:
- Selects which time source and which field pair drive the 4-digit FND display controller (`digit_h`, `digit_l`, `dot`).
- Shares the single display between the watch core and the stopwatch core.
- Sequences four views under button control, with dot blinking and an auto-return timer.
- Sits between the watch/stopwatch datapaths and the FND controller, in the 100 MHz domain.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency; derives the 1 ms tick (CLK_HZ/1000 cycles).
- AUTO_SEC, 5, idle seconds before auto-return to the watch hour:minute view.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high
- btn_mode  input  1  debounced single-cycle pulse; toggles watch/stopwatch domain
- btn_view  input  1  debounced single-cycle pulse; toggles field pair within domain
- w_hour  input  7  watch hour, 0-23
- w_min  input  7  watch minute, 0-59
- w_sec  input  7  watch second, 0-59
- w_csec  input  7  watch centisecond, 0-99
- s_min  input  7  stopwatch minute, 0-99
- s_sec  input  7  stopwatch second, 0-59
- s_csec  input  7  stopwatch centisecond, 0-99
- s_running  input  1  stopwatch counting
- digit_h  output  7  left two-digit value
- digit_l  output  7  right two-digit value
- dot  output  1  active-low decimal point (0 = lit)
- view  output  2  current state encoding, for LEDs

Behaviour:
- Clock and reset:
  - Clock clk. Reset reset, asynchronous, active-high.
  - Reset values: state W_HM, view=2'b00, digit_h=0, digit_l=0, dot=1, all counters 0.
- States and encoding:
  - W_HM=00: digit_h=w_hour, digit_l=w_min.
  - W_SC=01: digit_h=w_sec, digit_l=w_csec.
  - S_MS=10: digit_h=s_min, digit_l=s_sec.
  - S_SC=11: digit_h=s_sec, digit_l=s_csec.
- Transitions, evaluated on the btn pulse cycle:
  - btn_mode: W_HM/W_SC -> S_MS; S_MS/S_SC -> W_HM.
  - btn_view: W_HM<->W_SC; S_MS<->S_SC.
  - Both pulses in the same cycle: btn_mode wins, btn_view is discarded.
- Latency:
  - digit_h, digit_l, dot and view are registered.
  - They reflect a new state or input value exactly one clk after it.
  - No combinational path from any input to any output.
- Width and range rules:
  - Any source value >99 is clamped to 99 before registering.
  - Source values are not range-checked otherwise.
- Timebase:
  - ms counter counts 0..CLK_HZ/1000-1 and pulses tick_1ms on wrap.
  - half counter counts ticks 0..499 and toggles phase on wrap.
  - Both counters are free-running and unaffected by buttons.
- Dot, all values active-low:
  - W_HM: dot=phase, so it is lit for the first 500 ms after reset, then 1 Hz 50% duty.
  - W_SC: dot=0 (solid).
  - S_MS/S_SC: dot=~s_running, lit while the stopwatch runs.
- Auto-return (see optional feature):
  - idle counter counts tick_1ms while in S_MS/S_SC with s_running=0.
  - It clears on any btn pulse, on s_running=1, or in a watch state.
  - Reaching AUTO_SEC*1000 forces W_HM on the next clk and clears the counter.
  - Button pulses on that same cycle have priority over auto-return.
- Reset mid-operation: immediate return to reset values; any in-flight idle count is discarded.

Optional Feature:
- Macro: AUTO_RETURN_EN.
- Defined: idle counter and auto-return logic are present as above.
- Undefined: idle counter is not synthesised; stopwatch views persist until btn_mode.

Test Plan:
- Bench CLK_HZ=10_000 (tick every 10 clk). Reset with w_hour=13, w_min=45 -> after release and one clk, digit_h=13, digit_l=45, view=00, dot=0.
- Dot blink: from reset release, hold W_HM -> dot=0 for clk 1..5000, dot=1 for 5001..10000, dot=0 again at 10001.
- btn_mode pulse, then btn_view pulse, with s_min=2, s_sec=7, s_csec=88 -> view 10 with 2/7, then 11 with 7/88. Raise s_running=1 -> dot=0 one clk later.
- Simultaneous btn_mode+btn_view in W_SC -> next state S_MS (view=10), not W_HM.
- Drive w_csec=120 in W_SC -> digit_l=99.
- AUTO_RETURN_EN: in S_MS with s_running=0 and no buttons, view=10 until 50,000 clk, then view=00.
  - A btn_view at 30,000 clk restarts the count.
  - Without the macro, view stays 10 beyond 100,000 clk.
